lpm_lookup_ctrl: RTL and testbench
==================================

Name: lpm_lookup_ctrl

Overview:
Lookup engine that sits directly upstream of the LPM memory stage. It accepts a 32-bit key with a tag, walks a 3-level 16/8/8 stride trie by issuing one memory request per level, and consumes each response. It returns the leaf value, or a miss indication, to the downstream consumer. One lookup is in flight at a time, because the memory supports a single outstanding request.

Parameters:
KEY_W, 32, key width; fixed at 32, and L0_BITS + L1_BITS + L2_BITS must equal KEY_W
L0_BITS, 16, stride of level 0 (key[31:16])
L1_BITS, 8, stride of level 1 (key[15:8])
L2_BITS, 8, stride of level 2 (key[7:0])
ROOT_BASE, 32'h0, base address of the level-0 table

Ports:
CLK  in  1  clock
RST  in  1  reset
ifc$enter__ENA  in  1  start a lookup
ifc$enter$key  in  32  lookup key
ifc$enter$tag  in  32  opaque tag, returned with the result
ifc$enter__RDY  out  1  engine idle
ifc$result__RDY  out  1  result valid
ifc$result$value  out  32  leaf value, or last entry on a miss
ifc$result$tag  out  32  tag of the completed lookup
ifc$result$miss  out  1  last level reached without a leaf
ifc$result$levels  out  2  memory trips used (1..3)
ifc$resultAccept__ENA  in  1  consumer takes the result
mem$req__ENA  out  1  memory request
mem$req$v  out  96  request word {c,b,a}
mem$req__RDY  in  1  memory can take a request
mem$resValue  in  96  memory response word {c,b,a}
mem$resValue__RDY  in  1  response valid
mem$resAccept__ENA  out  1  consume the response
mem$resAccept__RDY  in  1  memory allows the accept
lookups_done  out  32  completed-lookup counter

Interface decision: one clock (CLK); reset (RST) is synchronous and active-high.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE; level, base, key, tag, entry and lookups_done cleared to 0.
  - All __ENA outputs and ifc$result__RDY are 0; ifc$enter__RDY is 1 in the first cycle after reset.
- Reset mid-operation: the lookup is abandoned with no result. RST must also be applied to the memory in the same cycle so that no stale response survives.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ifc$enter__RDY=1.
  - On ifc$enter__ENA: latch key and tag; base=ROOT_BASE; level=0; go to ISSUE.
  - An ENA seen while RDY=0 is ignored, with no state change.
- ISSUE:
  - mem$req__ENA = mem$req__RDY (combinational).
  - mem$req$v: a = addr, b = {30'b0, level}, c = tag.
  - addr = base + zero-extended key chunk for the current level, mod 2^32 (wraps).
  - Go to WAIT in the cycle the ENA fires; otherwise stay in ISSUE.
- WAIT:
  - mem$resAccept__ENA = mem$resValue__RDY & mem$resAccept__RDY (combinational).
  - In that cycle, sample entry = mem$resValue[31:0]. Fields b and c of the response are ignored.
  - If entry[31]=1 (leaf): value = {1'b0, entry[30:0]}, miss=0, go to DONE.
  - Else if level==2: value = {1'b0, entry[30:0]}, miss=1, go to DONE.
  - Else: base = {1'b0, entry[30:0]}, level = level+1, go to ISSUE.
- Latency per trip: 1 ISSUE cycle + memory latency + 1 accept cycle. Minimum lookup is 1 trip; maximum is 3.
- DONE:
  - ifc$result__RDY=1; result$levels = level+1. All result fields are held stable until accepted.
  - On ifc$resultAccept__ENA: lookups_done += 1 (wraps at 2^32); go to IDLE.
  - The next enter can fire at the earliest one cycle after the accept.
- Single-outstanding rule: mem$req__ENA is never asserted while a response is pending (WAIT or DONE).
- resultAccept__ENA while ifc$result__RDY=0 is ignored.

Decomposition:
- Shared package (lpm_pkg): state encoding; ENTRY_LEAF_BIT=31; LPM_MAX_LEVEL=2; field offsets for a/b/c within the 96-bit word; the struct typedef for the memory word.
- One natural sub-module, lpm_addr_gen: combinational; inputs base, key and level; output addr. It holds the stride-select and add logic.

Test Plan:
1. One-level hit:
   - Stimulus: key=32'h0A01_0203, tag=7; mem[0x0A01]=32'h8000_0055.
   - Response: one req with a=0x0A01; result value=0x55, tag=7, miss=0, levels=1; lookups_done=1.
2. Three-level hit:
   - Stimulus: mem[0x0A01]=0x0000_1000; mem[0x1002]=0x0000_2000; mem[0x2003]=0x8000_0099.
   - Response: req addresses 0x0A01, 0x1002, 0x2003 in order, with b = 0, 1, 2; value=0x99, levels=3.
3. Miss:
   - Stimulus: as test 2, but mem[0x2003]=0x0000_3000.
   - Response: miss=1, value=0x3000, levels=3; no fourth request.
4. Backpressure:
   - Stimulus: hold mem$req__RDY=0 for 5 cycles; then, in DONE, hold ifc$resultAccept__ENA=0 for 10 cycles.
   - Response: state holds in ISSUE with no req fire; result fields stable; ifc$enter__RDY=0 throughout; enter pulses during that time are ignored.
5. Address wrap:
   - Stimulus: ROOT_BASE=32'hFFFF_0001, key=32'hFFFF_0000.
   - Response: first request a=32'h0000_0000.
6. Reset mid-WAIT:
   - Stimulus: assert RST during WAIT at level 1 (memory reset too).
   - Response: next cycle state=IDLE, enter__RDY=1, no result, lookups_done=0; a following lookup completes normally.

Source files
------------

// File: rtl/lpm_pkg.sv
// rtl/lpm_pkg.sv - shared types and constants for the LPM trie lookup engine
package lpm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } lpm_state_e;

   localparam int         ENTRY_LEAF_BIT = 31;
   localparam logic [1:0] LPM_MAX_LEVEL  = 2'd2;

   localparam int FIELD_A_LSB = 0;
   localparam int FIELD_B_LSB = 32;
   localparam int FIELD_C_LSB = 64;

   // Packed MSB-first so the 96-bit word reads {c, b, a}.
   typedef struct packed {
      logic [31:0] c;
      logic [31:0] b;
      logic [31:0] a;
   } lpm_word_t;

endpackage

// File: rtl/lpm_addr_gen.sv
// rtl/lpm_addr_gen.sv - per-level table address: base plus the key chunk for that level
module lpm_addr_gen #(
   parameter int KEY_W   = 32,
   parameter int L0_BITS = 16,
   parameter int L1_BITS = 8,
   parameter int L2_BITS = 8
) (
   input  logic [31:0]      base_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [1:0]       level_i,
   output logic [31:0]      addr_o
);

   logic [31:0] chunk;

   always_comb begin
      chunk = '0;
      case (level_i)
         2'd0:    chunk[L0_BITS-1:0] = key_i[KEY_W-1 -: L0_BITS];
         2'd1:    chunk[L1_BITS-1:0] = key_i[L1_BITS+L2_BITS-1 -: L1_BITS];
         default: chunk[L2_BITS-1:0] = key_i[L2_BITS-1:0];
      endcase
   end

   // Plain 32-bit add; overflow wraps by construction.
   assign addr_o = base_i + chunk;

endmodule

// File: rtl/lpm_lookup_ctrl.sv
// rtl/lpm_lookup_ctrl.sv - 16/8/8 trie walker, one memory request outstanding at a time
module lpm_lookup_ctrl
   import lpm_pkg::*;
#(
   parameter int          KEY_W     = 32,
   parameter int          L0_BITS   = 16,
   parameter int          L1_BITS   = 8,
   parameter int          L2_BITS   = 8,
   parameter logic [31:0] ROOT_BASE = 32'h0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ifc_enter_ena_i,
   input  logic [31:0] ifc_enter_key_i,
   input  logic [31:0] ifc_enter_tag_i,
   output logic        ifc_enter_rdy_o,
   output logic        ifc_result_rdy_o,
   output logic [31:0] ifc_result_value_o,
   output logic [31:0] ifc_result_tag_o,
   output logic        ifc_result_miss_o,
   output logic [1:0]  ifc_result_levels_o,
   input  logic        ifc_result_accept_ena_i,
   output logic        mem_req_ena_o,
   output logic [95:0] mem_req_v_o,
   input  logic        mem_req_rdy_i,
   input  logic [95:0] mem_res_value_i,
   input  logic        mem_res_value_rdy_i,
   output logic        mem_res_accept_ena_o,
   input  logic        mem_res_accept_rdy_i,
   output logic [31:0] lookups_done_o
);

   lpm_state_e  state_q, state_d;
   logic [1:0]  level_q, level_d;
   logic [31:0] base_q, base_d;
   logic [31:0] key_q, key_d;
   logic [31:0] tag_q, tag_d;
   logic [31:0] entry_q, entry_d;
   logic [31:0] count_q, count_d;

   logic [31:0] addr;
   logic [31:0] res_entry;
   lpm_word_t   req_w;
   logic        unused_res_bits;

   lpm_addr_gen #(
      .KEY_W  (KEY_W),
      .L0_BITS(L0_BITS),
      .L1_BITS(L1_BITS),
      .L2_BITS(L2_BITS)
   ) u_addr_gen (
      .base_i (base_q),
      .key_i  (key_q),
      .level_i(level_q),
      .addr_o (addr)
   );

   assign res_entry       = mem_res_value_i[FIELD_A_LSB +: 32];
   assign unused_res_bits = ^{mem_res_value_i[FIELD_B_LSB +: 32], mem_res_value_i[FIELD_C_LSB +: 32]};

   always_comb begin
      req_w.a = addr;
      req_w.b = {30'b0, level_q};
      req_w.c = tag_q;
   end
   assign mem_req_v_o = req_w;

   always_comb begin
      state_d              = state_q;
      level_d              = level_q;
      base_d               = base_q;
      key_d                = key_q;
      tag_d                = tag_q;
      entry_d              = entry_q;
      count_d              = count_q;
      ifc_enter_rdy_o      = 1'b0;
      ifc_result_rdy_o     = 1'b0;
      mem_req_ena_o        = 1'b0;
      mem_res_accept_ena_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ifc_enter_rdy_o = 1'b1;
            if (ifc_enter_ena_i) begin
               key_d   = ifc_enter_key_i;
               tag_d   = ifc_enter_tag_i;
               base_d  = ROOT_BASE;
               level_d = 2'd0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_req_ena_o = mem_req_rdy_i;
            if (mem_req_rdy_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            mem_res_accept_ena_o = mem_res_value_rdy_i & mem_res_accept_rdy_i;
            if (mem_res_accept_ena_o) begin
               entry_d = res_entry;
               // A non-leaf at the last level is a miss; its payload is still reported.
               if (res_entry[ENTRY_LEAF_BIT] || (level_q == LPM_MAX_LEVEL)) begin
                  state_d = ST_DONE;
               end else begin
                  base_d  = {1'b0, res_entry[30:0]};
                  level_d = level_q + 2'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            ifc_result_rdy_o = 1'b1;
            if (ifc_result_accept_ena_i) begin
               count_d = count_q + 32'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         base_q  <= '0;
         key_q   <= '0;
         tag_q   <= '0;
         entry_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         base_q  <= base_d;
         key_q   <= key_d;
         tag_q   <= tag_d;
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign ifc_result_value_o  = {1'b0, entry_q[30:0]};
   assign ifc_result_tag_o    = tag_q;
   assign ifc_result_miss_o   = ~entry_q[ENTRY_LEAF_BIT];
   assign ifc_result_levels_o = level_q + 2'd1;
   assign lookups_done_o      = count_q;

endmodule

// File: tb/tb_lpm_lookup_ctrl.sv
// tb/tb_lpm_lookup_ctrl.sv - randomized self-checking bench for lpm_lookup_ctrl
module tb_lpm_lookup_ctrl;

   logic        CLK;
   logic        RST;
   logic        enter_ena;
   logic [31:0] enter_key;
   logic [31:0] enter_tag;
   logic        enter_rdy;
   logic        result_rdy;
   logic [31:0] result_value;
   logic [31:0] result_tag;
   logic        result_miss;
   logic [1:0]  result_levels;
   logic        result_accept;
   logic        mem_req_ena;
   logic [95:0] mem_req_v;
   logic        mem_req_rdy;
   logic [95:0] mem_res_val;
   logic        mem_res_rdy;
   logic        mem_acc_ena;
   logic        mem_acc_rdy;
   logic [31:0] lookups_done;

   // Second instance with a root base chosen to force address wrap.
   logic        w_enter_ena;
   logic        w_enter_rdy, w_result_rdy, w_result_miss, w_req_ena, w_acc_ena;
   logic [31:0] w_result_value, w_result_tag, w_lookups_done;
   logic [1:0]  w_result_levels;
   logic [95:0] w_req_v;

   int checks = 0;
   int errors = 0;

   lpm_lookup_ctrl u_dut (
      .CLK(CLK), .RST(RST),
      .ifc_enter_ena_i(enter_ena), .ifc_enter_key_i(enter_key), .ifc_enter_tag_i(enter_tag),
      .ifc_enter_rdy_o(enter_rdy), .ifc_result_rdy_o(result_rdy),
      .ifc_result_value_o(result_value), .ifc_result_tag_o(result_tag),
      .ifc_result_miss_o(result_miss), .ifc_result_levels_o(result_levels),
      .ifc_result_accept_ena_i(result_accept),
      .mem_req_ena_o(mem_req_ena), .mem_req_v_o(mem_req_v), .mem_req_rdy_i(mem_req_rdy),
      .mem_res_value_i(mem_res_val), .mem_res_value_rdy_i(mem_res_rdy),
      .mem_res_accept_ena_o(mem_acc_ena), .mem_res_accept_rdy_i(mem_acc_rdy),
      .lookups_done_o(lookups_done)
   );

   lpm_lookup_ctrl #(.ROOT_BASE(32'hFFFF_0001)) u_dut_wrap (
      .CLK(CLK), .RST(RST),
      .ifc_enter_ena_i(w_enter_ena), .ifc_enter_key_i(32'hFFFF_0000), .ifc_enter_tag_i(32'd5),
      .ifc_enter_rdy_o(w_enter_rdy), .ifc_result_rdy_o(w_result_rdy),
      .ifc_result_value_o(w_result_value), .ifc_result_tag_o(w_result_tag),
      .ifc_result_miss_o(w_result_miss), .ifc_result_levels_o(w_result_levels),
      .ifc_result_accept_ena_i(1'b0),
      .mem_req_ena_o(w_req_ena), .mem_req_v_o(w_req_v), .mem_req_rdy_i(1'b1),
      .mem_res_value_i(96'h0), .mem_res_value_rdy_i(1'b0),
      .mem_res_accept_ena_o(w_acc_ena), .mem_res_accept_rdy_i(1'b0),
      .lookups_done_o(w_lookups_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [31:0] mem_tbl [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem_tbl.exists(a) ? mem_tbl[a] : 32'h0;
   endfunction

   function automatic logic [31:0] key_chunk(input logic [31:0] key, input int lvl);
      if (lvl == 0) return key >> 16;
      if (lvl == 1) return (key >> 8) & 32'hFF;
      return key & 32'hFF;
   endfunction

   // Reference walk over the table: addresses visited, final value, miss flag, trips.
   logic [31:0] exp_addr_q[$];
   task automatic model_lookup(input logic [31:0] root, input logic [31:0] key,
                               output logic [31:0] val, output logic miss, output int levels);
      logic [31:0] base, a, e;
      base = root;
      exp_addr_q.delete();
      val = 0; miss = 0; levels = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         a = base + key_chunk(key, lvl);
         exp_addr_q.push_back(a);
         e = mem_rd(a);
         levels = lvl + 1;
         val = e & 32'h7FFF_FFFF;
         if (e >= 32'h8000_0000) begin miss = 0; return; end
         if (lvl == 2) begin miss = 1; return; end
         base = e & 32'h7FFF_FFFF;
      end
   endtask

   // Memory responder: single outstanding request, random readiness and latency.
   logic [31:0] req_addr_q[$], req_b_q[$], req_c_q[$];
   int          viol;
   bit          hold_req;
   bit          pending;
   bit          was_pending;
   logic [31:0] cur_addr;
   int          lat;

   initial begin
      mem_req_rdy = 0; mem_res_rdy = 0; mem_res_val = '0; mem_acc_rdy = 0;
      pending = 0; viol = 0; hold_req = 0; lat = 0; cur_addr = 0;
      forever begin
         @(negedge CLK); #1;
         was_pending = pending;
         if (RST) begin
            pending = 0; mem_req_rdy = 0; mem_res_rdy = 0; mem_acc_rdy = 0;
         end else if (!pending) begin
            mem_res_rdy = 0;
            mem_acc_rdy = 1'($urandom_range(0, 1));
            mem_req_rdy = hold_req ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (mem_req_ena) begin
               req_addr_q.push_back(mem_req_v[31:0]);
               req_b_q.push_back(mem_req_v[63:32]);
               req_c_q.push_back(mem_req_v[95:64]);
               cur_addr = mem_req_v[31:0];
               lat = $urandom_range(0, 3);
               pending = 1;
            end
         end else begin
            mem_req_rdy = 1'($urandom_range(0, 1));
            if (lat > 0) begin
               lat--;
               mem_res_rdy = 0;
               mem_acc_rdy = 1'($urandom_range(0, 1));
               #1;
            end else begin
               mem_res_rdy = 1;
               mem_res_val = {$urandom, $urandom, mem_rd(cur_addr)};
               mem_acc_rdy = ($urandom_range(0, 3) != 0);
               #1;
               if (mem_acc_ena) pending = 0;
            end
            if (was_pending && mem_req_ena) viol++;
         end
      end
   end

   int          exp_done = 0;
   logic [31:0] last_value;
   logic        last_miss;
   logic [1:0]  last_levels;

   task automatic do_lookup(input logic [31:0] key, input logic [31:0] tag,
                            input int hold_req_cyc, input int hold_acc_cyc);
      logic [31:0] ev;
      logic        em;
      int          el, n;
      model_lookup(32'h0, key, ev, em, el);
      req_addr_q.delete(); req_b_q.delete(); req_c_q.delete();
      viol = 0;
      n = 0;
      while (!enter_rdy && n < 100) begin @(negedge CLK); n++; end
      if (n == 100) begin chk("idle_timeout", 0, 1); return; end
      hold_req  = (hold_req_cyc > 0);
      enter_ena = 1; enter_key = key; enter_tag = tag;
      @(negedge CLK);
      enter_ena = 0;
      for (int i = 0; i < hold_req_cyc; i++) begin
         #3;
         chk("bp_req_ena", mem_req_ena, 0);
         chk("bp_enter_rdy", enter_rdy, 0);
         enter_ena = 1; enter_key = ~key; enter_tag = ~tag; result_accept = 1;
         @(negedge CLK);
         enter_ena = 0; result_accept = 0;
      end
      hold_req = 0;
      n = 0;
      while (!result_rdy && n < 300) begin @(negedge CLK); n++; end
      if (n == 300) begin chk("result_timeout", 0, 1); return; end
      #3;
      last_value = result_value; last_miss = result_miss; last_levels = result_levels;
      chk("value", result_value, ev);
      chk("tag", result_tag, tag);
      chk("miss", result_miss, em);
      chk("levels", result_levels, el);
      for (int i = 0; i < hold_acc_cyc; i++) begin
         enter_ena = 1; enter_key = $urandom; enter_tag = $urandom;
         @(negedge CLK); #3;
         chk("hold_value", result_value, ev);
         chk("hold_tag", result_tag, tag);
         chk("hold_rdy", result_rdy, 1);
         chk("hold_enter_rdy", enter_rdy, 0);
      end
      enter_ena = 0;
      chk("nreq", req_addr_q.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size(); i++) begin
         if (i < req_addr_q.size()) begin
            chk("req_addr", req_addr_q[i], exp_addr_q[i]);
            chk("req_level", req_b_q[i], i);
            chk("req_tag", req_c_q[i], tag);
         end
      end
      chk("single_outstanding", viol, 0);
      @(negedge CLK);
      result_accept = 1;
      @(negedge CLK);
      result_accept = 0;
      #3;
      exp_done++;
      chk("lookups_done", lookups_done, exp_done);
      chk("post_enter_rdy", enter_rdy, 1);
      chk("post_result_rdy", result_rdy, 0);
   endtask

   task automatic build_random_trie(input logic [31:0] key);
      logic [31:0] base, a, t, e;
      base = 0;
      mem_tbl.delete();
      for (int lvl = 0; lvl < 3; lvl++) begin
         a = base + key_chunk(key, lvl);
         t = $urandom;
         e = ($urandom_range(0, 2) == 0) ? (t | 32'h8000_0000) : (t & 32'h7FFF_FFFF);
         mem_tbl[a] = e;
         if (e >= 32'h8000_0000) break;
         base = e & 32'h7FFF_FFFF;
      end
   endtask

   initial begin
      int n;
      logic [31:0] k;
      RST = 1; enter_ena = 0; enter_key = 0; enter_tag = 0; result_accept = 0; w_enter_ena = 0;
      repeat (3) @(negedge CLK);
      #3;
      chk("rst_enter_rdy", enter_rdy, 1);
      chk("rst_result_rdy", result_rdy, 0);
      chk("rst_req_ena", mem_req_ena, 0);
      chk("rst_acc_ena", mem_acc_ena, 0);
      chk("rst_lookups_done", lookups_done, 0);
      @(negedge CLK);
      RST = 0;

      w_enter_ena = 1;
      @(negedge CLK);
      w_enter_ena = 0;
      #3;
      chk("wrap_req_ena", w_req_ena, 1);
      chk("wrap_addr", w_req_v[31:0], 32'h0);

      mem_tbl.delete();
      mem_tbl[32'h0A01] = 32'h8000_0055;
      do_lookup(32'h0A01_0203, 32'd7, 0, 0);
      chk("t1_value", last_value, 32'h55);
      chk("t1_levels", last_levels, 1);

      mem_tbl[32'h0A01] = 32'h0000_1000;
      mem_tbl[32'h1002] = 32'h0000_2000;
      mem_tbl[32'h2003] = 32'h8000_0099;
      do_lookup(32'h0A01_0203, 32'd8, 0, 0);
      chk("t2_value", last_value, 32'h99);
      chk("t2_levels", last_levels, 3);

      mem_tbl[32'h2003] = 32'h0000_3000;
      do_lookup(32'h0A01_0203, 32'd9, 5, 10);
      chk("t3_miss", last_miss, 1);
      chk("t3_value", last_value, 32'h3000);
      chk("t3_levels", last_levels, 3);

      mem_tbl[32'h2003] = 32'h8000_0099;
      while (!enter_rdy) @(negedge CLK);
      req_b_q.delete(); req_addr_q.delete(); req_c_q.delete();
      enter_ena = 1; enter_key = 32'h0A01_0203; enter_tag = 32'd11;
      @(negedge CLK);
      enter_ena = 0;
      n = 0;
      while (req_b_q.size() < 2 && n < 200) begin @(negedge CLK); #3; n++; end
      chk("rst_mid_reach_l1", req_b_q.size(), 2);
      @(negedge CLK);
      RST = 1;
      @(negedge CLK);
      RST = 0;
      #3;
      exp_done = 0;
      chk("rst_mid_enter_rdy", enter_rdy, 1);
      chk("rst_mid_result_rdy", result_rdy, 0);
      chk("rst_mid_lookups_done", lookups_done, 0);
      chk("rst_mid_req_ena", mem_req_ena, 0);
      do_lookup(32'h0A01_0203, 32'd12, 0, 0);
      chk("t6_value", last_value, 32'h99);

      for (int it = 0; it < 40; it++) begin
         k = $urandom;
         build_random_trie(k);
         do_lookup(k, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
